// File: rtl/gecko_load_writeback.sv
// gecko_load_writeback
//   Load-completion stage after gecko execute. Buffers load descriptors issued
//   by execute, pairs each one in order with the data word returned by data
//   memory, then aligns and sign/zero-extends the loaded value. The result is
//   held in an output register toward writeback.
//
//   Handshake rule on every stream: a transfer happens on a rising clock edge
//   where valid and ready are both high. A source holds valid and payload
//   stable until that transfer. A sink may raise or lower ready freely.
//
// Ports
//   clk, rst                      clock; synchronous active-low reset
//   mem_command_valid_i/ready_o   load descriptor stream from execute
//   mem_command_addr_i            destination register (5 bits)
//   mem_command_op_i              load funct3
//   mem_command_offset_i          byte offset inside the word
//   mem_result_valid_i/ready_o    data-memory response, returned in order
//   mem_result_data_i             32-bit response word
//   load_result_valid_o/ready_i   register-write result toward writeback
//   load_result_value_o           extended load value
//   load_result_addr_o            destination register
//   load_result_speculative_o     always 0
//   dbg_occupancy_o               descriptor FIFO occupancy, for observation
module gecko_load_writeback #(
   parameter int COMMAND_DEPTH = 4,
   localparam int PW = $clog2(COMMAND_DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_command_valid_i,
   output logic          mem_command_ready_o,
   input  logic [4:0]    mem_command_addr_i,
   input  logic [2:0]    mem_command_op_i,
   input  logic [1:0]    mem_command_offset_i,
   input  logic          mem_result_valid_i,
   output logic          mem_result_ready_o,
   input  logic [31:0]   mem_result_data_i,
   output logic          load_result_valid_o,
   input  logic          load_result_ready_i,
   output logic [31:0]   load_result_value_o,
   output logic [4:0]    load_result_addr_o,
   output logic          load_result_speculative_o,
   output logic [CW-1:0] dbg_occupancy_o
);

   // Descriptor packed as {addr, op, offset}.
   logic [9:0]    fifo_q [COMMAND_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          cmd_ready_q, cmd_ready_d;

   logic          out_valid_q;
   logic [31:0]   out_value_q;
   logic [4:0]    out_addr_q;

   logic          cmd_hs;
   logic          res_hs;
   logic [4:0]    head_addr;
   logic [2:0]    head_op;
   logic [1:0]    head_offset;
   logic [7:0]    sel_byte;
   logic [15:0]   sel_half;
   logic [31:0]   ext_value;

   assign {head_addr, head_op, head_offset} = fifo_q[rd_ptr_q];

   // Command ready is registered from next-cycle occupancy, so a full FIFO
   // keeps ready low for the whole cycle even while its head is being popped,
   // and reset reaches the port only through this register.
   assign mem_command_ready_o = cmd_ready_q;
   assign cmd_hs              = mem_command_valid_i && cmd_ready_q;

   // Accept a response only when a descriptor is waiting and the output
   // register is free or being drained this cycle.
   assign mem_result_ready_o = (count_q != '0) && (!out_valid_q || load_result_ready_i);
   assign res_hs             = mem_result_valid_i && mem_result_ready_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (cmd_hs) wr_ptr_d = wr_ptr_q + PW'(1);
      if (res_hs) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({cmd_hs, res_hs})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      cmd_ready_d = (count_d < CW'(COMMAND_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (cmd_hs) fifo_q[wr_ptr_q] <= {mem_command_addr_i, mem_command_op_i, mem_command_offset_i};
   end

   always_comb begin
      sel_byte = 8'h00;
      case (head_offset)
         2'd0: sel_byte = mem_result_data_i[7:0];
         2'd1: sel_byte = mem_result_data_i[15:8];
         2'd2: sel_byte = mem_result_data_i[23:16];
         2'd3: sel_byte = mem_result_data_i[31:24];
         default: sel_byte = 8'h00;
      endcase
      // Halfword uses only offset bit 1; bit 0 is ignored.
      sel_half = head_offset[1] ? mem_result_data_i[31:16] : mem_result_data_i[15:0];

      ext_value = 32'h0;
      case (head_op)
         3'b000:  ext_value = {{24{sel_byte[7]}}, sel_byte};
         3'b001:  ext_value = {{16{sel_half[15]}}, sel_half};
         3'b010:  ext_value = mem_result_data_i;
         3'b100:  ext_value = {24'h0, sel_byte};
         3'b101:  ext_value = {16'h0, sel_half};
         default: ext_value = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_value_q <= 32'h0;
         out_addr_q  <= 5'h0;
      end else if (res_hs) begin
         out_valid_q <= 1'b1;
         out_value_q <= ext_value;
         out_addr_q  <= head_addr;
      end else if (load_result_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

   assign load_result_valid_o       = out_valid_q;
   assign load_result_value_o       = out_value_q;
   assign load_result_addr_o        = out_addr_q;
   assign load_result_speculative_o = 1'b0;
   assign dbg_occupancy_o           = count_q;

endmodule

// File: tb/tb_gecko_load_writeback.sv
// Bench for gecko_load_writeback: directed descriptors and responses with
// hand-computed results pushed into an expected queue; a monitor pops and
// compares each result accepted by the sink.
module tb_gecko_load_writeback;

   localparam int EW = 38; // {speculative, addr, value}

   logic        clk;
   logic        rst;
   logic        mem_command_valid;
   logic        mem_command_ready;
   logic [4:0]  mem_command_addr;
   logic [2:0]  mem_command_op;
   logic [1:0]  mem_command_offset;
   logic        mem_result_valid;
   logic        mem_result_ready;
   logic [31:0] mem_result_data;
   logic        load_result_valid;
   logic        load_result_ready;
   logic [31:0] load_result_value;
   logic [4:0]  load_result_addr;
   logic        load_result_speculative;
   logic [2:0]  dbg_occupancy;

   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   gecko_load_writeback #(.COMMAND_DEPTH(4)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .mem_command_valid_i       (mem_command_valid),
      .mem_command_ready_o       (mem_command_ready),
      .mem_command_addr_i        (mem_command_addr),
      .mem_command_op_i          (mem_command_op),
      .mem_command_offset_i      (mem_command_offset),
      .mem_result_valid_i        (mem_result_valid),
      .mem_result_ready_o        (mem_result_ready),
      .mem_result_data_i         (mem_result_data),
      .load_result_valid_o       (load_result_valid),
      .load_result_ready_i       (load_result_ready),
      .load_result_value_o       (load_result_value),
      .load_result_addr_o        (load_result_addr),
      .load_result_speculative_o (load_result_speculative),
      .dbg_occupancy_o           (dbg_occupancy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst && load_result_valid && load_result_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", {load_result_speculative, load_result_addr, load_result_value}, '1);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("result", {load_result_speculative, load_result_addr, load_result_value}, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_cmd(input logic [4:0] addr, input logic [2:0] op, input logic [1:0] off);
      bit seen = 0;
      mem_command_valid  = 1'b1;
      mem_command_addr   = addr;
      mem_command_op     = op;
      mem_command_offset = off;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (mem_command_ready) seen = 1;
      end
      if (!seen) check("cmd_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      mem_command_valid = 1'b0;
   endtask

   task automatic push_resp(input logic [31:0] data, input logic [4:0] addr, input logic [31:0] exp_val);
      bit seen = 0;
      mem_result_valid = 1'b1;
      mem_result_data  = data;
      exp_q.push_back({1'b0, addr, exp_val});
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (mem_result_ready) seen = 1;
      end
      if (!seen) check("resp_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      mem_result_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // ---------------- extraction vectors ----------------
   localparam int NV = 8;
   logic [2:0]  v_op  [NV] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011, 3'b000, 3'b001};
   logic [1:0]  v_off [NV] = '{2'd3,   2'd1,   2'd2,   2'd0,   2'd2,   2'd1,   2'd0,   2'd1};
   logic [31:0] v_exp [NV] = '{32'hFFFF_FF8F, 32'h0000_0080, 32'hFFFF_8F7F, 32'h0000_80FF,
                               32'h8F7F_80FF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_80FF};

   // ---------------- stimulus ----------------
   initial begin
      rst                = 1'b0;
      mem_command_valid  = 1'b0;
      mem_command_addr   = '0;
      mem_command_op     = '0;
      mem_command_offset = '0;
      mem_result_valid   = 1'b0;
      mem_result_data    = '0;
      load_result_ready  = 1'b1;

      // Reset then idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", load_result_valid, 1'b0);
      check("rst_res_ready", mem_result_ready, 1'b0);
      check("rst_cmd_ready", mem_command_ready, 1'b0);
      check("rst_payload", {load_result_addr, load_result_value}, '0);
      step();
      rst = 1'b1;
      step();
      check("idle_cmd_ready", mem_command_ready, 1'b1);
      check("idle_occ", dbg_occupancy, 3'd0);

      // Extraction sweep on d = 0x8F7F_80FF
      for (int i = 0; i < NV; i++) begin
         push_cmd(5'(i + 1), v_op[i], v_off[i]);
         push_resp(32'h8F7F_80FF, 5'(i + 1), v_exp[i]);
      end
      step();

      // Fill to depth 4 with no responses
      for (int i = 1; i <= 4; i++) push_cmd(5'(i), 3'b010, 2'd0);
      check("full_cmd_ready", mem_command_ready, 1'b0);
      check("full_occ", dbg_occupancy, 3'd4);
      push_resp(32'h0000_00A1, 5'd1, 32'h0000_00A1);
      check("unfull_cmd_ready", mem_command_ready, 1'b1);
      push_resp(32'h0000_00A2, 5'd2, 32'h0000_00A2);
      push_resp(32'h0000_00A3, 5'd3, 32'h0000_00A3);
      push_resp(32'h0000_00A4, 5'd4, 32'h0000_00A4);
      step();

      // Ordering: three results in consecutive cycles
      push_cmd(5'd5, 3'b010, 2'd0);
      push_cmd(5'd6, 3'b010, 2'd0);
      push_cmd(5'd7, 3'b010, 2'd0);
      mem_result_valid = 1'b1;
      mem_result_data  = 32'h11;
      exp_q.push_back({1'b0, 5'd5, 32'h11});
      @(negedge clk); check("ord_rdy0", mem_result_ready, 1'b1);
      step();
      check("ord_v0", load_result_valid, 1'b1);
      mem_result_data = 32'h22;
      exp_q.push_back({1'b0, 5'd6, 32'h22});
      @(negedge clk); check("ord_rdy1", mem_result_ready, 1'b1);
      step();
      check("ord_v1", load_result_valid, 1'b1);
      mem_result_data = 32'h33;
      exp_q.push_back({1'b0, 5'd7, 32'h33});
      @(negedge clk); check("ord_rdy2", mem_result_ready, 1'b1);
      step();
      mem_result_valid = 1'b0;
      check("ord_v2", load_result_valid, 1'b1);
      step();
      check("ord_idle", load_result_valid, 1'b0);

      // Back-pressure
      load_result_ready = 1'b0;
      push_cmd(5'd9, 3'b010, 2'd0);
      push_resp(32'h0000_1234, 5'd9, 32'h0000_1234);
      push_cmd(5'd10, 3'b010, 2'd0);
      mem_result_valid = 1'b1;
      mem_result_data  = 32'h0000_5678;
      exp_q.push_back({1'b0, 5'd10, 32'h0000_5678});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_res_ready", mem_result_ready, 1'b0);
         check("bp_hold", {load_result_valid, load_result_addr, load_result_value}, {1'b1, 5'd9, 32'h0000_1234});
      end
      step();
      load_result_ready = 1'b1;
      @(negedge clk); check("bp_release_ready", mem_result_ready, 1'b1);
      step();
      mem_result_valid = 1'b0;
      check("bp_next_valid", load_result_valid, 1'b1);
      step();
      check("bp_idle", load_result_valid, 1'b0);

      // Response before any descriptor
      mem_result_valid = 1'b1;
      mem_result_data  = 32'hCAFE_0000;
      exp_q.push_back({1'b0, 5'd12, 32'h0000_CAFE});
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("empty_res_ready", mem_result_ready, 1'b0);
      end
      step();
      mem_command_valid  = 1'b1;
      mem_command_addr   = 5'd12;
      mem_command_op     = 3'b101;
      mem_command_offset = 2'd2;
      step();
      mem_command_valid = 1'b0;
      check("empty_accept_n1", mem_result_ready, 1'b1);
      check("empty_no_valid_n1", load_result_valid, 1'b0);
      step();
      mem_result_valid = 1'b0;
      check("empty_valid_n2", load_result_valid, 1'b1);
      step();

      // Reset mid-stream
      load_result_ready = 1'b0;
      push_cmd(5'd1, 3'b010, 2'd0);
      push_resp(32'hDEAD_BEEF, 5'd1, 32'hDEAD_BEEF);
      push_cmd(5'd2, 3'b010, 2'd0);
      push_cmd(5'd3, 3'b010, 2'd0);
      check("mid_occ", dbg_occupancy, 3'd2);
      check("mid_valid", load_result_valid, 1'b1);
      rst = 1'b0;
      exp_q.delete();
      step();
      check("mid_rst_valid", load_result_valid, 1'b0);
      check("mid_rst_occ", dbg_occupancy, 3'd0);
      check("mid_rst_res_ready", mem_result_ready, 1'b0);
      check("mid_rst_payload", {load_result_addr, load_result_value}, '0);
      rst = 1'b1;
      load_result_ready = 1'b1;
      step();
      check("recover_cmd_ready", mem_command_ready, 1'b1);
      push_cmd(5'd20, 3'b000, 2'd1);
      push_resp(32'h0000_7F00, 5'd20, 32'h0000_007F);
      repeat (3) step();
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      check("global_timeout", 1'b0, 1'b1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gecko_load_writeback.md
# gecko_load_writeback

Load-completion stage directly downstream of the gecko execute stage. Queues the load descriptors execute issues on its mem command stream (`gecko_mem_operation_t`). Pairs each descriptor in order with the data word returned by data memory, then byte/halfword-aligns and sign/zero-extends it. Emits a registered `gecko_operation_t` register-write result toward writeback.

## Interface
- `COMMAND_DEPTH`, default 4: number of outstanding load descriptors buffered. Power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-low; one clock domain.
- `mem_command`  in  `std_stream_intf`  load descriptors from execute. Payload `gecko_mem_operation_t`:
  - `addr`: 5-bit destination register.
  - `op`: 3-bit load funct3.
  - `offset`: 2-bit byte offset.
- `mem_result`  in  `std_mem_intf`  data-memory read response: `valid`, `ready`, 32-bit `data`. Responses return in request order.
- `load_result`  out  `std_stream_intf`  payload `gecko_operation_t`: `value` 32, `addr` 5, `speculative` 1.

## Operation
- Command FIFO: COMMAND_DEPTH entries; write pointer, read pointer and occupancy counter (0..COMMAND_DEPTH).
  - `mem_command.ready` = occupancy < COMMAND_DEPTH. Registered entry: a descriptor written in cycle N is visible at the head in cycle N+1. No bypass.
  - Full FIFO: `mem_command.ready` stays low even if a dequeue occurs the same cycle.
  - Pointers wrap modulo COMMAND_DEPTH.
- Response acceptance: `mem_result.ready` = (occupancy > 0) && (!`load_result.valid` || `load_result.ready`).
  - Response handshake pops the FIFO head and loads the output register.
  - A response arriving with FIFO empty is held off (ready low); it is not dropped.
- Extraction, with d = response data and o = head `offset`:
  - LB (000): sign-extend d[8*o+7:8*o].
  - LH (001): sign-extend d[16*o[1]+15:16*o[1]]; o[0] ignored.
  - LW (010): d unchanged; o ignored.
  - LBU (100): zero-extend byte as LB.
  - LHU (101): zero-extend half as LH.
  - Any other funct3: value 0.
- Output payload:
  - `addr` = head `addr`.
  - `speculative` = 0 always.
- Output register holds valid/payload until `load_result.ready`. Payload is stable while valid && !ready.
- Simultaneous enqueue and dequeue: occupancy unchanged and both pointers advance.
- Reset (any cycle, including mid-stream): FIFO contents discarded; in-flight responses are the upstream owner's concern.

## Timing
- Reset values:
  - `load_result.valid` = 0; `load_result.payload` = 0.
  - `mem_command.ready` = 1 from the first cycle after reset deassertion; 0 while `rst` is low.
  - `mem_result.ready` = 0.
  - Occupancy, read pointer and write pointer = 0.
- Latency: response accepted in cycle N → `load_result.valid` in N+1.
- Command-to-earliest-acceptance: descriptor accepted in N → its response can be accepted in N+1.
- Throughput: one load per cycle sustained when the FIFO is non-empty and the sink is ready.
- `load_result.ready` combinationally feeds `mem_result.ready`. No combinational path from `mem_command` to `mem_result.ready`.
- No output depends combinationally on `rst` except through registers.

## Test plan
- Reset then idle:
  - `rst`=0 for 3 cycles → `load_result.valid`=0, `mem_result.ready`=0.
  - After release, `mem_command.ready`=1 and occupancy 0.
- Extraction sweep with d=0x8F7F_80FF:
  - LB o=3 → 0xFFFF_FF8F.
  - LBU o=1 → 0x0000_0080.
  - LH o=2 → 0xFFFF_8F7F.
  - LHU o=0 → 0x0000_80FF.
  - LW → 0x8F7F_80FF.
  - funct3=011 → 0.
  - `addr` echoes the descriptor; `speculative`=0.
- Fill: push 4 descriptors (COMMAND_DEPTH=4) with no responses → `mem_command.ready`=0 after the 4th. Push one response → ready=1 the next cycle.
- Ordering: descriptors to x5, x6, x7 with responses 0x11, 0x22, 0x33 → outputs (x5,0x11), (x6,0x22), (x7,0x33) in three consecutive cycles.
- Back-pressure: hold `load_result.ready`=0 with a pending response → `mem_result.ready`=0 and output payload stable. Raise ready → next result in the following cycle.
- Empty-FIFO response: assert `mem_result.valid` before any descriptor → ready=0. Descriptor accepted cycle N → response accepted N+1, result valid N+2.
- Reset mid-stream: 2 descriptors queued and output valid, assert `rst` → all state cleared next edge, valid=0.
